block_dispatcher: RTL and testbench

Parametrised block dispatcher for the compute-core array: it splits a kernel's thread count into blocks of THREADS_PER_BLOCK threads and hands them to a configurable number of cores. It runs a start/done handshake with each core and reuses cores as they finish, so the number of blocks is not limited to NUM_CORES. It gives each core its block id and the size of the final partial block. It also adds an abort path and a busy flag. It sits between the device control register and the compute cores, beside the data and program memory controllers.

---
 rtl/block_dispatcher.sv | 142 ++++++++++++++
 tb/tb_block_dispatcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_dispatcher.sv
// Block dispatcher: splits a kernel's threads into fixed-size blocks and hands them
// to a pool of compute cores over a start/done handshake, reusing cores as they finish.
module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 8,
  parameter int BLOCK_ID_BITS     = 8,
  localparam int TPB_BITS         = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic [THREAD_COUNT_BITS-1:0]       thread_count,
  input  logic [NUM_CORES-1:0]               core_done,
  output logic [NUM_CORES-1:0]               core_start,
  output logic [NUM_CORES-1:0]               core_reset,
  output logic [NUM_CORES*BLOCK_ID_BITS-1:0] core_block_id,
  output logic [NUM_CORES*TPB_BITS-1:0]      core_thread_count,
  output logic                               busy,
  output logic                               done
);

  localparam int TPB_SHIFT = $clog2(THREADS_PER_BLOCK);
  localparam int CW        = THREAD_COUNT_BITS + 1;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] RESET_CORES = 2'd1;
  localparam logic [1:0] DISPATCH    = 2'd2;
  localparam logic [1:0] DONE        = 2'd3;

  logic [1:0]                   state;
  logic [THREAD_COUNT_BITS-1:0] tc_lat;
  logic [CW-1:0]                total_blocks;
  logic [CW-1:0]                dispatched;
  logic [CW-1:0]                completed;

  logic [NUM_CORES-1:0] free_cores;
  logic [NUM_CORES-1:0] grant;
  logic [NUM_CORES-1:0] done_hits;
  logic [CW-1:0]        done_cnt;
  logic [CW-1:0]        block_base;
  logic [CW-1:0]        last_count;
  logic                 dispatch_ok;
  logic                 last_block;

  // One extra bit keeps ceil() from overflowing when thread_count is near full scale.
  function automatic logic [CW-1:0] ceil_blocks(input logic [THREAD_COUNT_BITS-1:0] n);
    return ({1'b0, n} + CW'(THREADS_PER_BLOCK - 1)) >> TPB_SHIFT;
  endfunction

  // A core is free only once both its run flag and its reset pulse have dropped.
  assign free_cores  = ~core_start & ~core_reset;
  assign grant       = free_cores & (~free_cores + NUM_CORES'(1));
  assign done_hits   = core_done & core_start;
  assign dispatch_ok = (dispatched < total_blocks) && (|free_cores);
  assign last_block  = (dispatched == total_blocks - CW'(1));
  assign block_base  = dispatched << TPB_SHIFT;
  assign last_count  = {1'b0, tc_lat} - block_base;

  // NOTE: assign a default before the loop so the block stays purely combinational.
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + CW'(done_hits[i]);
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      tc_lat            <= '0;
      total_blocks      <= '0;
      dispatched        <= '0;
      completed         <= '0;
      core_start        <= '0;
      core_reset        <= '0;
      core_block_id     <= '0;
      core_thread_count <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      core_reset <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            tc_lat       <= thread_count;
            total_blocks <= ceil_blocks(thread_count);
            dispatched   <= '0;
            completed    <= '0;
            core_start   <= '0;
            if (thread_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state      <= RESET_CORES;
              core_reset <= '1;
              done       <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end

        RESET_CORES, DISPATCH: begin
          if (abort) begin
            core_start <= '0;
            core_reset <= '1;
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
          end else if (state == RESET_CORES) begin
            state <= DISPATCH;
          end else if (completed == total_blocks) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            // Completions and a new dispatch never touch the same core: the granted core is idle.
            core_start <= (core_start & ~done_hits) | (dispatch_ok ? grant : '0);
            core_reset <= done_hits;
            completed  <= completed + done_cnt;
            if (dispatch_ok) begin
              dispatched <= dispatched + CW'(1);
              for (int i = 0; i < NUM_CORES; i++) begin
                if (grant[i]) begin
                  core_block_id[i*BLOCK_ID_BITS +: BLOCK_ID_BITS] <= BLOCK_ID_BITS'(dispatched);
                  core_thread_count[i*TPB_BITS +: TPB_BITS] <=
                    last_block ? last_count[TPB_BITS-1:0] : TPB_BITS'(THREADS_PER_BLOCK);
                end
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: a bench-side core responder drives core_done and a
// transaction-level reference model predicts every output after every clock edge.
module tb_block_dispatcher;

  localparam int NC   = 2;
  localparam int TPB  = 4;
  localparam int TCB  = 8;
  localparam int BIB  = 4;
  localparam int TPBB = $clog2(TPB) + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                abort;
  logic [TCB-1:0]      thread_count;
  logic [NC-1:0]       core_done;
  logic [NC-1:0]       core_start;
  logic [NC-1:0]       core_reset;
  logic [NC*BIB-1:0]   core_block_id;
  logic [NC*TPBB-1:0]  core_thread_count;
  logic                busy;
  logic                done;

  always #5 clk = ~clk;

  block_dispatcher #(
    .NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .THREAD_COUNT_BITS(TCB), .BLOCK_ID_BITS(BIB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .thread_count(thread_count),
    .core_done(core_done), .core_start(core_start), .core_reset(core_reset),
    .core_block_id(core_block_id), .core_thread_count(core_thread_count),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  typedef enum {M_IDLE, M_PREP, M_RUN, M_FIN} phase_e;
  phase_e m_phase;
  int     m_tc, m_blocks, m_issued, m_finished;
  bit     e_start[NC];
  bit     e_reset[NC];
  int     e_id[NC];
  int     e_cnt[NC];
  bit     e_busy, e_done;

  int timer[NC];
  int resp_mode;     // 0: random latency + spurious done on idle cores, 1: fixed per-core latency, 2: all at once
  int resp_lat[NC];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_tc = 0; m_blocks = 0; m_issued = 0; m_finished = 0;
    e_busy = 0; e_done = 0;
    for (int i = 0; i < NC; i++) begin
      e_start[i] = 0; e_reset[i] = 0; e_id[i] = 0; e_cnt[i] = 0; timer[i] = 0;
    end
  endtask

  // Predicted effect of one clock edge, given the inputs present at that edge.
  task automatic model_edge(bit s, bit a, int tc, logic [NC-1:0] cd);
    bit old_start[NC];
    bit old_reset[NC];
    int pick;
    old_start = e_start;
    old_reset = e_reset;
    case (m_phase)
      M_IDLE, M_FIN: begin
        for (int i = 0; i < NC; i++) e_reset[i] = 0;
        if (s) begin
          m_tc = tc; m_blocks = (tc + TPB - 1) / TPB; m_issued = 0; m_finished = 0;
          for (int i = 0; i < NC; i++) e_start[i] = 0;
          if (tc == 0) begin
            m_phase = M_FIN; e_done = 1; e_busy = 0;
          end else begin
            m_phase = M_PREP; e_done = 0; e_busy = 1;
            for (int i = 0; i < NC; i++) e_reset[i] = 1;
          end
        end
      end
      default: begin
        if (a) begin
          for (int i = 0; i < NC; i++) begin e_start[i] = 0; e_reset[i] = 1; end
          m_phase = M_IDLE; e_busy = 0; e_done = 0;
        end else if (m_phase == M_PREP) begin
          for (int i = 0; i < NC; i++) e_reset[i] = 0;
          m_phase = M_RUN;
        end else if (m_finished == m_blocks) begin
          for (int i = 0; i < NC; i++) e_reset[i] = 0;
          m_phase = M_FIN; e_done = 1; e_busy = 0;
        end else begin
          for (int i = 0; i < NC; i++) begin
            e_reset[i] = 0;
            if (cd[i] && old_start[i]) begin
              e_start[i] = 0; e_reset[i] = 1; m_finished++;
            end
          end
          if (m_issued < m_blocks) begin
            pick = -1;
            for (int i = 0; i < NC; i++)
              if (pick < 0 && !old_start[i] && !old_reset[i]) pick = i;
            if (pick >= 0) begin
              e_start[pick] = 1;
              e_id[pick]    = m_issued % (1 << BIB);
              e_cnt[pick]   = (m_issued == m_blocks - 1) ? m_tc - m_issued * TPB : TPB;
              m_issued++;
            end
          end
        end
      end
    endcase
  endtask

  task automatic compare(string tag);
    logic [NC-1:0]      s, r;
    logic [NC*BIB-1:0]  id;
    logic [NC*TPBB-1:0] c;
    for (int i = 0; i < NC; i++) begin
      s[i] = e_start[i];
      r[i] = e_reset[i];
      id[i*BIB +: BIB]  = BIB'(e_id[i]);
      c[i*TPBB +: TPBB] = TPBB'(e_cnt[i]);
    end
    check({tag, ".core_start"},        64'(core_start),        64'(s));
    check({tag, ".core_reset"},        64'(core_reset),        64'(r));
    check({tag, ".core_block_id"},     64'(core_block_id),     64'(id));
    check({tag, ".core_thread_count"}, 64'(core_thread_count), 64'(c));
    check({tag, ".busy"},              64'(busy),              64'(e_busy));
    check({tag, ".done"},              64'(done),              64'(e_done));
  endtask

  task automatic cycle(bit s, bit a, int tc, string tag);
    logic [NC-1:0] cd;
    bit prev[NC];
    bit all_run;
    cd = '0;
    if (resp_mode == 2) begin
      all_run = 1;
      for (int i = 0; i < NC; i++) if (!e_start[i]) all_run = 0;
      cd = all_run ? '1 : '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (e_start[i]) begin
          if (timer[i] == 0) cd[i] = 1'b1;
          else timer[i]--;
        end else if (resp_mode == 0) begin
          cd[i] = ($urandom_range(0, 3) == 0);
        end
      end
    end
    start = s; abort = a; thread_count = TCB'(tc); core_done = cd;
    prev = e_start;
    @(posedge clk);
    model_edge(s, a, tc, cd);
    #1;
    compare(tag);
    for (int i = 0; i < NC; i++)
      if (e_start[i] && !prev[i]) timer[i] = (resp_mode == 0) ? $urandom_range(0, 5) : resp_lat[i];
  endtask

  // Launches a kernel, then keeps poking start/thread_count randomly while it runs.
  task automatic run_kernel(int tc, int mode, string tag);
    int n;
    resp_mode = mode;
    cycle(1, 0, tc, {tag, ".launch"});
    n = 0;
    while ((m_phase == M_PREP || m_phase == M_RUN) && n < 2000) begin
      cycle($urandom_range(0, 1), 0, $urandom_range(0, 255), tag);
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $error("FAIL %s.budget: kernel still running after %0d cycles", tag, n);
    end
  endtask

  task automatic idle(int n, string tag);
    for (int k = 0; k < n; k++) cycle(0, 0, $urandom_range(0, 255), tag);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; abort = 1'b0; thread_count = '0; core_done = '0;
    resp_mode = 1;
    model_reset();
    #12;
    compare("reset");
    #10 reset = 1'b1;
    idle(2, "post_reset");

    // Two full blocks, both cores answer after a fixed latency.
    resp_lat[0] = 4; resp_lat[1] = 4;
    run_kernel(8, 1, "tc8");
    idle(3, "tc8.hold");

    // Partial last block lands on core1, which finishes first.
    resp_lat[0] = 6; resp_lat[1] = 0;
    run_kernel(10, 1, "tc10");
    idle(4, "tc10.hold");

    // Empty kernel: done right away, no core activity.
    run_kernel(0, 1, "tc0");
    idle(3, "tc0.hold");

    // Simultaneous completions, then relaunch straight from DONE.
    run_kernel(8, 2, "sync8");
    run_kernel(16, 2, "sync16");
    cycle(0, 1, 3, "abort_in_done");

    // Abort with 3 of 5 blocks issued.
    resp_mode = 0;
    cycle(1, 0, 20, "abort.launch");
    n = 0;
    while (m_issued < 3 && n < 200) begin
      cycle(0, 0, $urandom_range(0, 255), "abort.run");
      n++;
    end
    cycle(0, 1, 0, "abort.hit");
    idle(2, "abort.idle");
    cycle(0, 1, 0, "abort_in_idle");
    run_kernel(4, 0, "after_abort");

    // Random kernels, including full-scale counts that wrap the block id.
    for (int k = 0; k < 12; k++) begin
      int tc;
      tc = (k == 0) ? 255 : (k == 1) ? 1 : (k == 2) ? 4 : int'($urandom_range(0, 255));
      run_kernel(tc, 0, "rand");
      cycle(0, $urandom_range(0, 1), 0, "rand.done");
    end

    // Asynchronous reset in the middle of a kernel.
    run_kernel(0, 0, "pre_areset");
    resp_mode = 0;
    cycle(1, 0, 40, "areset.launch");
    idle(8, "areset.run");
    #3 reset = 1'b0;
    #1;
    check("areset.core_start",        64'(core_start),        64'd0);
    check("areset.core_reset",        64'(core_reset),        64'd0);
    check("areset.core_block_id",     64'(core_block_id),     64'd0);
    check("areset.core_thread_count", 64'(core_thread_count), 64'd0);
    check("areset.busy",              64'(busy),              64'd0);
    check("areset.done",              64'(done),              64'd0);
    model_reset();
    start = 1'b0;
    core_done = '0;
    @(posedge clk);
    #2 reset = 1'b1;
    idle(3, "areset.idle");
    run_kernel(12, 0, "areset.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
